// File: rtl/conv5_layer_sequencer_pkg.sv
// Shared types and constants for the 5x5 convolution layer sequencer.
package conv5_layer_sequencer_pkg;

    localparam int unsigned KERNEL_TAPS = 25;
    localparam int unsigned KIDX_W      = 5;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_K,
        STREAM,
        FLUSH,
        DONE
    } seq_state_t;

    function automatic int unsigned calc_n_out(input int unsigned width,
                                               input int unsigned height,
                                               input int unsigned stride);
        return ((width + stride - 1) / stride) * ((height + stride - 1) / stride);
    endfunction

endpackage

// File: rtl/conv5_layer_sequencer_if.sv
// Job control, weight stream, pixel/output memory and engine signals of the sequencer.
interface conv5_layer_sequencer_if #(
    parameter int unsigned Datawidth = 16,
    parameter int unsigned ADDR_W    = 16
);
    import conv5_layer_sequencer_pkg::*;

    logic                               Start;
    logic                               Reuse_K;
    logic                               Busy;
    logic                               Done;
    logic                               Err;
    logic                               W_Valid;
    logic [Datawidth-1:0]               W_Data;
    logic                               W_Ready;
    logic [KERNEL_TAPS*Datawidth-1:0]   K_Flat;
    logic                               Pix_RdEn;
    logic [ADDR_W-1:0]                  Pix_Addr;
    logic [Datawidth-1:0]               Pix_Data;
    logic                               Eng_CLR;
    logic                               Eng_Valid_IN;
    logic [Datawidth-1:0]               Eng_In;
    logic                               Eng_Valid_OUT;
    logic [Datawidth-1:0]               Eng_Out;
    logic                               Out_WrEn;
    logic [ADDR_W-1:0]                  Out_Addr;
    logic [Datawidth-1:0]               Out_Data;

    modport master (
        input  Start, Reuse_K, W_Valid, W_Data, Pix_Data, Eng_Valid_OUT, Eng_Out,
        output Busy, Done, Err, W_Ready, K_Flat, Pix_RdEn, Pix_Addr,
               Eng_CLR, Eng_Valid_IN, Eng_In, Out_WrEn, Out_Addr, Out_Data
    );

    modport slave (
        output Start, Reuse_K, W_Valid, W_Data, Pix_Data, Eng_Valid_OUT, Eng_Out,
        input  Busy, Done, Err, W_Ready, K_Flat, Pix_RdEn, Pix_Addr,
               Eng_CLR, Eng_Valid_IN, Eng_In, Out_WrEn, Out_Addr, Out_Data
    );

endinterface

// File: rtl/conv5_layer_sequencer_regbank.sv
// 25-entry kernel coefficient register file, presented as one flat vector.
module conv5_kernel_regbank
    import conv5_layer_sequencer_pkg::*;
#(
    parameter int unsigned Datawidth = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [KIDX_W-1:0]                idx,
    input  logic [Datawidth-1:0]             data,
    output logic [KERNEL_TAPS*Datawidth-1:0] k_flat
);

    logic [Datawidth-1:0] taps [KERNEL_TAPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= '{default: '0};
        end else if (wr_en && ({{(32-KIDX_W){1'b0}}, idx} < KERNEL_TAPS)) begin
            taps[idx] <= data;
        end
    end

    for (genvar g = 0; g < KERNEL_TAPS; g++) begin : g_flat
        assign k_flat[g*Datawidth +: Datawidth] = taps[g];
    end

endmodule

// File: rtl/conv5_layer_sequencer.sv
// Job-level controller: clears the engine, loads the kernel, streams pixels, flushes and stores results.
module conv5_layer_sequencer
    import conv5_layer_sequencer_pkg::*;
#(
    parameter int unsigned IMG_Width  = 5,
    parameter int unsigned IMG_Height = 5,
    parameter int unsigned Datawidth  = 16,
    parameter int unsigned Stride     = 1,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned MAX_FLUSH  = 3 * IMG_Width
) (
    input  logic                   CLK,
    input  logic                   CLR,
    conv5_layer_sequencer_if.master bus
);

    localparam int unsigned       N_PIX     = IMG_Width * IMG_Height;
    localparam int unsigned       N_OUT     = calc_n_out(IMG_Width, IMG_Height, Stride);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(N_PIX - 1);
    localparam logic [ADDR_W-1:0] OUT_MAX   = ADDR_W'(N_OUT);
    localparam logic [ADDR_W-1:0] FLUSH_MAX = ADDR_W'(MAX_FLUSH);

    seq_state_t                       state, state_nxt;
    logic [KIDX_W-1:0]                k_idx;
    logic [ADDR_W-1:0]                pix_cnt;
    logic [ADDR_W-1:0]                out_cnt;
    logic [ADDR_W-1:0]                flush_cnt;
    logic                             err;
    logic                             reuse_q;
    logic                             pix_vld;
    logic                             out_wr;
    logic [ADDR_W-1:0]                out_addr;
    logic [Datawidth-1:0]             out_data;
    logic                             k_we;
    logic                             timeout;
    logic [KERNEL_TAPS*Datawidth-1:0] k_flat;

    always_ff @(posedge CLK) begin
        if (CLR) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        k_we             = 1'b0;
        timeout          = 1'b0;
        bus.Busy         = (state != IDLE);
        bus.Done         = (state == DONE);
        bus.Err          = err;
        bus.W_Ready      = (state == LOAD_K);
        bus.Pix_RdEn     = (state == STREAM);
        bus.Pix_Addr     = pix_cnt;
        bus.Eng_CLR      = CLR | (state == CLEAR);
        // The first FLUSH cycle still carries the last image pixel (pix_vld), so the
        // zero forcing applies only to beats with no read in flight.
        bus.Eng_Valid_IN = pix_vld | (state == FLUSH);
        bus.Eng_In       = pix_vld ? bus.Pix_Data : '0;
        bus.Out_WrEn     = out_wr;
        bus.Out_Addr     = out_addr;
        bus.Out_Data     = out_data;
        bus.K_Flat       = k_flat;
        case (state)
            IDLE:    if (bus.Start) state_nxt = CLEAR;
            CLEAR:   state_nxt = reuse_q ? STREAM : LOAD_K;
            LOAD_K: begin
                if (bus.W_Valid) begin
                    k_we = 1'b1;
                    if (k_idx == KIDX_W'(KERNEL_TAPS - 1)) state_nxt = STREAM;
                end
            end
            STREAM:  if (pix_cnt == LAST_PIX) state_nxt = FLUSH;
            FLUSH: begin
                if (out_cnt == OUT_MAX) begin
                    state_nxt = DONE;
                end else if (flush_cnt == FLUSH_MAX) begin
                    state_nxt = DONE;
                    timeout   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            k_idx     <= '0;
            pix_cnt   <= '0;
            out_cnt   <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
            reuse_q   <= 1'b0;
            pix_vld   <= 1'b0;
            out_wr    <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            pix_vld <= (state == STREAM);
            out_wr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        err       <= 1'b0;
                        pix_cnt   <= '0;
                        out_cnt   <= '0;
                        flush_cnt <= '0;
                        k_idx     <= '0;
                        reuse_q   <= bus.Reuse_K;
                    end
                end
                LOAD_K:  if (k_we) k_idx <= k_idx + KIDX_W'(1);
                STREAM:  pix_cnt <= pix_cnt + ADDR_W'(1);
                FLUSH: begin
                    flush_cnt <= flush_cnt + ADDR_W'(1);
                    if (timeout) err <= 1'b1;
                end
                default: ;
            endcase
            // Results past the expected count are dropped; out_cnt saturates at N_OUT.
            if ((state == STREAM || state == FLUSH) && bus.Eng_Valid_OUT && (out_cnt < OUT_MAX)) begin
                out_wr   <= 1'b1;
                out_addr <= out_cnt;
                out_data <= bus.Eng_Out;
                out_cnt  <= out_cnt + ADDR_W'(1);
            end
        end
    end

    conv5_kernel_regbank #(
        .Datawidth(Datawidth)
    ) u_regbank (
        .clk   (CLK),
        .rst   (CLR),
        .wr_en (k_we),
        .idx   (k_idx),
        .data  (bus.W_Data),
        .k_flat(k_flat)
    );

endmodule

// File: tb/tb_conv5_layer_sequencer.sv
// Directed bench for conv5_layer_sequencer with a behavioural engine and pixel memory.
module tb_conv5_layer_sequencer;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    conv5_layer_sequencer_if #(.Datawidth(16), .ADDR_W(16)) bus ();
    conv5_layer_sequencer_if #(.Datawidth(16), .ADDR_W(16)) bus2 ();

    conv5_layer_sequencer #(
        .IMG_Width(5), .IMG_Height(5), .Datawidth(16), .Stride(1), .ADDR_W(16), .MAX_FLUSH(15)
    ) dut (
        .CLK(clk), .CLR(clr), .bus(bus)
    );

    conv5_layer_sequencer #(
        .IMG_Width(5), .IMG_Height(5), .Datawidth(16), .Stride(2), .ADDR_W(16), .MAX_FLUSH(15)
    ) dut2 (
        .CLK(clk), .CLR(clr), .bus(bus2)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Pixel memory: pixel i holds i+1, one-cycle read latency.
    logic [15:0] pix_mem [0:31];
    always @(posedge clk) begin
        if (bus.Pix_RdEn) bus.Pix_Data <= pix_mem[bus.Pix_Addr[4:0]];
    end

    // Engine model: same-padded 5x5 with only the centre tap contributing,
    // so result j is K12 * input beat j, emitted when beat j+12 arrives.
    logic [15:0] eng_buf [0:63];
    int unsigned eng_n = 0;
    int unsigned eng_prod = 0;
    bit          eng_mute = 1'b0;
    logic [15:0] k12;
    assign k12 = bus.K_Flat[12*16 +: 16];

    always @(posedge clk) begin
        if (bus.Eng_CLR) begin
            eng_n             <= 0;
            eng_prod          <= 0;
            bus.Eng_Valid_OUT <= 1'b0;
            bus.Eng_Out       <= '0;
        end else begin
            bus.Eng_Valid_OUT <= 1'b0;
            if (bus.Eng_Valid_IN) begin
                if (eng_n < 64) eng_buf[6'(eng_n)] <= bus.Eng_In;
                eng_n <= eng_n + 1;
                if (eng_n >= 12 && eng_prod < 25 && !eng_mute) begin
                    bus.Eng_Valid_OUT <= 1'b1;
                    bus.Eng_Out       <= k12 * eng_buf[6'(eng_n - 12)];
                    eng_prod          <= eng_prod + 1;
                end
            end
        end
    end

    logic [15:0]  w_seq [0:24];
    logic [399:0] k_exp;
    logic [15:0]  wr_addr [0:31];
    logic [15:0]  wr_data [0:31];
    int unsigned  wr_n, done_n, busy_n, wready_n, vin_n;
    logic         err_at_done, err_first;

    task automatic build_k_exp();
        for (int unsigned i = 0; i < 25; i++) k_exp[i*16 +: 16] = w_seq[i];
    endtask

    // Runs one job on dut from a negedge in IDLE; returns at the negedge after DONE.
    task automatic run_job(input bit reuse, input bit stall);
        int unsigned kw;
        int unsigned cyc;
        bit          fin;
        kw = 0; cyc = 0; fin = 1'b0;
        wr_n = 0; done_n = 0; busy_n = 0; wready_n = 0; vin_n = 0; err_at_done = 1'b0;
        bus.Start   = 1'b1;
        bus.Reuse_K = reuse;
        @(negedge clk);
        bus.Start   = 1'b0;
        bus.Reuse_K = 1'b0;
        err_first   = bus.Err;
        while (!fin && cyc < 200) begin
            if (bus.Out_WrEn) begin
                if (wr_n < 32) begin
                    wr_addr[wr_n] = bus.Out_Addr;
                    wr_data[wr_n] = bus.Out_Data;
                end
                wr_n++;
            end
            if (bus.Busy)         busy_n++;
            if (bus.W_Ready)      wready_n++;
            if (bus.Eng_Valid_IN) vin_n++;
            if (bus.Done) begin
                done_n++;
                err_at_done = bus.Err;
                fin = 1'b1;
            end
            if (!reuse && kw < 25) begin
                bus.W_Valid = stall ? ((cyc % 2) == 0) : 1'b1;
                bus.W_Data  = w_seq[kw];
                if (bus.W_Valid && bus.W_Ready) kw++;
            end else begin
                bus.W_Valid = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bus.W_Valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.Busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        n_cmp++; if (bus.Done !== 1'b0)         begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
        n_cmp++; if (bus.Err !== 1'b0)          begin n_err++; $display("FAIL reset_err: got %b expected 0", bus.Err); end
        n_cmp++; if (bus.W_Ready !== 1'b0)      begin n_err++; $display("FAIL reset_wready: got %b expected 0", bus.W_Ready); end
        n_cmp++; if (bus.Pix_RdEn !== 1'b0)     begin n_err++; $display("FAIL reset_rden: got %b expected 0", bus.Pix_RdEn); end
        n_cmp++; if (bus.Eng_Valid_IN !== 1'b0) begin n_err++; $display("FAIL reset_vin: got %b expected 0", bus.Eng_Valid_IN); end
        n_cmp++; if (bus.Out_WrEn !== 1'b0)     begin n_err++; $display("FAIL reset_wren: got %b expected 0", bus.Out_WrEn); end
        n_cmp++; if (bus.Eng_CLR !== 1'b1)      begin n_err++; $display("FAIL reset_engclr: got %b expected 1", bus.Eng_CLR); end
        n_cmp++; if (bus.K_Flat !== '0)         begin n_err++; $display("FAIL reset_kflat: got %h expected 0", bus.K_Flat); end
        clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.Eng_CLR !== 1'b0)      begin n_err++; $display("FAIL idle_engclr: got %b expected 0", bus.Eng_CLR); end
    endtask

    task automatic test_identity();
        for (int unsigned i = 0; i < 25; i++) w_seq[i] = (i == 12) ? 16'd1 : 16'd0;
        build_k_exp();
        run_job(1'b0, 1'b0);
        n_cmp++; if (wr_n !== 25)        begin n_err++; $display("FAIL id_writes: got %0d expected 25", wr_n); end
        for (int unsigned i = 0; i < 25; i++) begin
            n_cmp++; if (wr_addr[i] !== 16'(i) || wr_data[i] !== 16'(i + 1)) begin
                n_err++; $display("FAIL id_write%0d: got addr %0d data %0d expected addr %0d data %0d", i, wr_addr[i], wr_data[i], i, i + 1);
            end
        end
        n_cmp++; if (done_n !== 1)       begin n_err++; $display("FAIL id_done: got %0d pulses expected 1", done_n); end
        n_cmp++; if (err_at_done !== 1'b0) begin n_err++; $display("FAIL id_err: got %b expected 0", err_at_done); end
        n_cmp++; if (wready_n !== 25)    begin n_err++; $display("FAIL id_wready: got %0d cycles expected 25", wready_n); end
        n_cmp++; if (busy_n !== 67)      begin n_err++; $display("FAIL id_length: got %0d expected 67", busy_n); end
        n_cmp++; if (vin_n !== 39)       begin n_err++; $display("FAIL id_beats: got %0d expected 39", vin_n); end
        n_cmp++; if (bus.K_Flat !== k_exp) begin n_err++; $display("FAIL id_kflat: got %h expected %h", bus.K_Flat, k_exp); end
        n_cmp++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            n_err++; $display("FAIL id_after: got busy %b done %b expected 0 0", bus.Busy, bus.Done);
        end
    endtask

    task automatic test_back_to_back_reuse();
        run_job(1'b1, 1'b0);
        n_cmp++; if (wready_n !== 0)     begin n_err++; $display("FAIL reuse_wready: got %0d cycles expected 0", wready_n); end
        n_cmp++; if (bus.K_Flat !== k_exp) begin n_err++; $display("FAIL reuse_kflat: got %h expected %h", bus.K_Flat, k_exp); end
        n_cmp++; if (wr_n !== 25)        begin n_err++; $display("FAIL reuse_writes: got %0d expected 25", wr_n); end
        for (int unsigned i = 0; i < 25; i++) begin
            n_cmp++; if (wr_addr[i] !== 16'(i) || wr_data[i] !== 16'(i + 1)) begin
                n_err++; $display("FAIL reuse_write%0d: got addr %0d data %0d expected addr %0d data %0d", i, wr_addr[i], wr_data[i], i, i + 1);
            end
        end
        n_cmp++; if (busy_n !== 42)      begin n_err++; $display("FAIL reuse_length: got %0d expected 42", busy_n); end
        n_cmp++; if (done_n !== 1)       begin n_err++; $display("FAIL reuse_done: got %0d pulses expected 1", done_n); end
    endtask

    task automatic test_weight_stall();
        for (int unsigned i = 0; i < 25; i++) w_seq[i] = 16'(16'h0100 + i);
        run_job(1'b0, 1'b1);
        for (int unsigned i = 0; i < 25; i++) begin
            n_cmp++; if (bus.K_Flat[i*16 +: 16] !== 16'(16'h0100 + i)) begin
                n_err++; $display("FAIL stall_k%0d: got %h expected %h", i, bus.K_Flat[i*16 +: 16], 16'(16'h0100 + i));
            end
        end
        n_cmp++; if (bus.K_Flat[24*16 +: 16] !== 16'h0118) begin n_err++; $display("FAIL stall_k24: got %h expected 0118", bus.K_Flat[24*16 +: 16]); end
        n_cmp++; if (wready_n !== 50)    begin n_err++; $display("FAIL stall_wready: got %0d cycles expected 50", wready_n); end
        n_cmp++; if (busy_n !== 92)      begin n_err++; $display("FAIL stall_length: got %0d expected 92", busy_n); end
        n_cmp++; if (wr_n !== 25)        begin n_err++; $display("FAIL stall_writes: got %0d expected 25", wr_n); end
        for (int unsigned i = 0; i < 25; i += 8) begin
            n_cmp++; if (wr_data[i] !== 16'(32'h10C * (i + 1))) begin
                n_err++; $display("FAIL stall_data%0d: got %h expected %h", i, wr_data[i], 16'(32'h10C * (i + 1)));
            end
        end
    endtask

    task automatic test_timeout();
        eng_mute = 1'b1;
        run_job(1'b1, 1'b0);
        eng_mute = 1'b0;
        n_cmp++; if (wr_n !== 0)          begin n_err++; $display("FAIL to_writes: got %0d expected 0", wr_n); end
        n_cmp++; if (done_n !== 1)        begin n_err++; $display("FAIL to_done: got %0d pulses expected 1", done_n); end
        n_cmp++; if (err_at_done !== 1'b1) begin n_err++; $display("FAIL to_err_done: got %b expected 1", err_at_done); end
        n_cmp++; if (busy_n !== 43)       begin n_err++; $display("FAIL to_length: got %0d expected 43", busy_n); end
        @(negedge clk);
        n_cmp++; if (bus.Err !== 1'b1)    begin n_err++; $display("FAIL to_err_sticky: got %b expected 1", bus.Err); end
        run_job(1'b1, 1'b0);
        n_cmp++; if (err_first !== 1'b0)  begin n_err++; $display("FAIL to_err_cleared: got %b expected 0", err_first); end
        n_cmp++; if (err_at_done !== 1'b0) begin n_err++; $display("FAIL to_err_next: got %b expected 0", err_at_done); end
        n_cmp++; if (wr_n !== 25)         begin n_err++; $display("FAIL to_next_writes: got %0d expected 25", wr_n); end
    endtask

    task automatic test_stride2();
        int unsigned n_wr  = 0;
        int unsigned pulse = 0;
        int unsigned cyc   = 0;
        int unsigned len   = 0;
        int unsigned dn    = 0;
        bit          fin   = 1'b0;
        bus2.Eng_Valid_OUT = 1'b1;
        bus2.Eng_Out       = 16'hDEAD;
        @(negedge clk);
        bus2.Eng_Valid_OUT = 1'b0;
        n_cmp++; if (bus2.Out_WrEn !== 1'b0) begin n_err++; $display("FAIL s2_idle_write: got %b expected 0", bus2.Out_WrEn); end
        bus2.Start   = 1'b1;
        bus2.Reuse_K = 1'b1;
        @(negedge clk);
        bus2.Start   = 1'b0;
        bus2.Reuse_K = 1'b0;
        while (!fin && cyc < 100) begin
            if (bus2.Out_WrEn) begin
                n_cmp++; if (bus2.Out_Addr !== 16'(n_wr) || bus2.Out_Data !== 16'(16'h0200 + n_wr)) begin
                    n_err++; $display("FAIL s2_write%0d: got addr %0d data %h expected addr %0d data %h", n_wr, bus2.Out_Addr, bus2.Out_Data, n_wr, 16'(16'h0200 + n_wr));
                end
                n_wr++;
            end
            if (bus2.Busy) len++;
            if (bus2.Done) begin dn++; fin = 1'b1; end
            if (bus2.Pix_RdEn && pulse < 12) begin
                bus2.Eng_Valid_OUT = 1'b1;
                bus2.Eng_Out       = 16'(16'h0200 + pulse);
                pulse++;
            end else begin
                bus2.Eng_Valid_OUT = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bus2.Eng_Valid_OUT = 1'b0;
        n_cmp++; if (n_wr !== 9)  begin n_err++; $display("FAIL s2_writes: got %0d expected 9", n_wr); end
        n_cmp++; if (dn !== 1)    begin n_err++; $display("FAIL s2_done: got %0d pulses expected 1", dn); end
        n_cmp++; if (len !== 28)  begin n_err++; $display("FAIL s2_length: got %0d expected 28", len); end
    endtask

    task automatic test_abort();
        int unsigned cyc = 0;
        int unsigned dn  = 0;
        bus.Start   = 1'b1;
        bus.Reuse_K = 1'b1;
        @(negedge clk);
        bus.Start   = 1'b0;
        bus.Reuse_K = 1'b0;
        while (!(bus.Pix_RdEn && bus.Pix_Addr == 16'd10) && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        n_cmp++; if (bus.Pix_Addr !== 16'd10 || bus.Pix_RdEn !== 1'b1) begin
            n_err++; $display("FAIL abort_reach: got addr %0d rden %b expected addr 10 rden 1", bus.Pix_Addr, bus.Pix_RdEn);
        end
        clr = 1'b1;
        #1;
        n_cmp++; if (bus.Eng_CLR !== 1'b1) begin n_err++; $display("FAIL abort_engclr: got %b expected 1", bus.Eng_CLR); end
        @(negedge clk);
        n_cmp++; if (bus.Busy !== 1'b0)     begin n_err++; $display("FAIL abort_busy: got %b expected 0", bus.Busy); end
        n_cmp++; if (bus.Pix_RdEn !== 1'b0) begin n_err++; $display("FAIL abort_rden: got %b expected 0", bus.Pix_RdEn); end
        n_cmp++; if (bus.K_Flat !== '0)     begin n_err++; $display("FAIL abort_kflat: got %h expected 0", bus.K_Flat); end
        n_cmp++; if (bus.Done !== 1'b0)     begin n_err++; $display("FAIL abort_done_now: got %b expected 0", bus.Done); end
        clr = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.Done) dn++;
        end
        n_cmp++; if (dn !== 0) begin n_err++; $display("FAIL abort_done: got %0d pulses expected 0", dn); end
    endtask

    initial begin
        for (int unsigned i = 0; i < 32; i++) pix_mem[i] = 16'(i + 1);
        bus.Start = 1'b0;  bus.Reuse_K = 1'b0;  bus.W_Valid = 1'b0;  bus.W_Data = '0;
        bus2.Start = 1'b0; bus2.Reuse_K = 1'b0; bus2.W_Valid = 1'b0; bus2.W_Data = '0;
        bus2.Pix_Data = '0; bus2.Eng_Valid_OUT = 1'b0; bus2.Eng_Out = '0;
        test_reset();
        test_identity();
        test_back_to_back_reuse();
        test_weight_stall();
        test_timeout();
        test_stride2();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
